regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between CPU writeback and NUM_REQ
//  external requesters, e.g. score injection into r30 or button status.
//  - CPU writeback always has priority and passes through with zero latency.
//  - Each external write is parked in a per-requester holding slot and retired
//    in a cycle where the CPU is not writing.
//  - Sits between processor/peripheral logic and regfile, replacing ad-hoc write muxing.
// PARAMETERS
//  NUM_REQ       4    number of external write requesters (1..8)
//  DATA_W        32   register data width
//  ADDR_W        5    register index width
//  STARVE_LIMIT  16   consecutive blocked cycles before cpu_stall_req asserts (>=2)
// PORTS
//  clk           in   1               system clock, rising edge
//  reset         in   1               asynchronous, active-high
//  cpu_we        in   1               CPU writeback enable
//  cpu_rd        in   ADDR_W          CPU destination register
//  cpu_data      in   DATA_W          CPU writeback data
//  req_valid     in   NUM_REQ         requester i has a write to post
//  req_rd        in   NUM_REQ*ADDR_W  packed destinations, slice i = [i*ADDR_W +: ADDR_W]
//  req_data      in   NUM_REQ*DATA_W  packed data, slice i = [i*DATA_W +: DATA_W]
//  req_ready     out  NUM_REQ         slot i empty; write accepted on valid&ready
//  rf_we         out  1               to regfile ctrl_writeEnable
//  rf_rd         out  ADDR_W          to regfile ctrl_writeReg
//  rf_data       out  DATA_W          to regfile data_writeReg
//  grant         out  NUM_REQ         one-hot: slot retired this cycle; 0 if CPU or idle
//  cpu_stall_req out  1               ask CPU to suppress writeback so slots drain
//  writes_done   out  16              saturating count of retired external writes
// BEHAVIOUR
//  Reset (async, while asserted):
//   - slots empty; rr pointer = 0; starve counter = 0; writes_done = 0.
//   - cpu_stall_req = 0; req_ready = 0; rf_we = 0; grant = 0.
//   - Pending slot data is discarded. A reset mid-operation is not replayed.
//  Slots: one register per requester (full, rd, data).
//   - req_ready[i] = !full[i] & !reset. This is a registered flag, never combinational from req_valid.
//   - Accept on valid&ready at clock edge. Slot is full from the next cycle.
//   - Max rate: one write per requester per 2 cycles.
//  Port mux (combinational, same cycle):
//   - cpu_we=1: rf_* = cpu_*, grant = 0. Slots hold.
//   - else if any slot full: round-robin pick, starting at rr pointer.
//     - rf_we=1; rf_rd/rf_data from the chosen slot; grant one-hot.
//     - On that edge the slot clears and rr pointer = winner+1 mod NUM_REQ.
//   - else: rf_we=0, rf_rd=0, rf_data=0.
//  r0 writes:
//   - A full slot with rd=0 is retired in the first non-CPU cycle, like any other slot.
//   - rf_we is 0 for that write; grant is still pulsed and writes_done still increments.
//  Same-register conflict:
//   - No merging or cancelling between CPU and slot writes to the same rd.
//   - CPU writes first; the slot retires later, so the last writer is the arbiter.
//   - Software convention reserves requester-owned registers (r30 = score).
//  Starvation:
//   - Counter increments each cycle with cpu_we=1 and >=1 slot full.
//   - Clears on any grant or when all slots are empty.
//   - cpu_stall_req (registered) sets when the counter reaches STARVE_LIMIT-1 on an edge.
//   - It stays high until the first grant, then clears on that edge.
//  writes_done: +1 per grant, saturating at 16'hFFFF.
//  Simultaneous events:
//   - Accept into slot j and grant of slot i in the same cycle is legal for i != j.
//   - i == j cannot occur because ready implies empty.
// STRUCTURE
//  - Package regfile_arb_pkg holds ADDR_W/DATA_W defaults, REG_SCORE = 5'd30, REG_ZERO = 5'd0.
//  - Sub-module rr_arbiter #(N): inputs req[N] and ptr; output one-hot gnt.
//    Purely combinational rotate/priority/unrotate.
//  - Top holds the slots, rr pointer, starve counter, stall flag, counter and port mux.
// TESTING
//  1. CPU only: cpu_we=1, rd=7, data=0x55 -> rf_we=1, rf_rd=7, rf_data=0x55 same cycle; grant=0.
//  2. Idle port: req0 posts rd=30, data=3, cpu_we=0.
//     -> ready0 drops next cycle; that cycle rf_we=1, rf_rd=30, rf_data=3, grant=0001; writes_done=1.
//  3. Round-robin: all 4 slots full, cpu_we=0 -> grants 0001,0010,0100,1000 on 4 consecutive cycles.
//     Refill all -> order resumes at 0001.
//  4. Starvation with STARVE_LIMIT=16: slot1 full, cpu_we held 1.
//     -> cpu_stall_req rises after 16 blocked cycles.
//     Drop cpu_we -> grant=0010 that cycle; stall_req low next cycle.
//  5. r0 and reset: slot2 posts rd=0 -> grant=0100 with rf_we=0.
//     Then assert reset asynchronously with slot3 full -> ready/grant/rf_we=0 at once; no write after release.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared defaults and well-known register indices for the regfile write arbiter.
package regfile_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic [4:0] REG_SCORE = 5'd30;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit,
// then rotate the one-hot result back into requester order.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot_req;
    logic [N-1:0] rot_gnt;

    always_comb begin
        rot_req = N'({req, req} >> ptr);
        rot_gnt = rot_req & (~rot_req + N'(1));
        gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between CPU writeback (priority, zero latency) and
// NUM_REQ external requesters parked in single-entry slots, with starvation stall request.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_we,
    input  logic [ADDR_W-1:0]          cpu_rd,
    input  logic [DATA_W-1:0]          cpu_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_rd,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_rd,
    output logic [DATA_W-1:0]          rf_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       cpu_stall_req,
    output logic [15:0]                writes_done
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(STARVE_LIMIT);

    logic [NUM_REQ-1:0] full;
    logic [ADDR_W-1:0]  slot_rd   [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic [PW-1:0]      rr_ptr;
    logic [CW-1:0]      starve_cnt;
    logic               stall_q;
    logic [15:0]        done_cnt;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [PW-1:0]      win_idx;
    logic               cpu_act;
    logic               slot_pick;
    logic               blocked;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (full),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rr_gnt[i]) win_idx = PW'(i);
        end
    end

    // CPU path is gated by reset so the port is quiet for the whole reset window.
    assign cpu_act   = cpu_we & ~reset;
    assign slot_pick = ~cpu_act & (|full);
    assign blocked   = cpu_act & (|full);

    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = '0;
        rf_data = '0;
        grant   = '0;
        if (cpu_act) begin
            rf_we   = 1'b1;
            rf_rd   = cpu_rd;
            rf_data = cpu_data;
        end else if (slot_pick) begin
            rf_we   = (slot_rd[win_idx] != ADDR_W'(REG_ZERO));
            rf_rd   = slot_rd[win_idx];
            rf_data = slot_data[win_idx];
            grant   = rr_gnt;
        end
    end

    assign req_ready     = ~full & {NUM_REQ{~reset}};
    assign cpu_stall_req = stall_q;
    assign writes_done   = done_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full       <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            done_cnt   <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                slot_rd[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    full[i] <= 1'b0;
                end else if (req_valid[i] && !full[i]) begin
                    full[i]      <= 1'b1;
                    slot_rd[i]   <= req_rd[i*ADDR_W +: ADDR_W];
                    slot_data[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end

            if (slot_pick) begin
                rr_ptr <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
            end

            if (slot_pick || !(|full)) begin
                starve_cnt <= '0;
            end else if (blocked && starve_cnt != CW'(STARVE_LIMIT - 1)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end

            // Stall rises on the blocked edge seen with the counter already at its cap.
            if (slot_pick) begin
                stall_q <= 1'b0;
            end else if (blocked && starve_cnt == CW'(STARVE_LIMIT - 1)) begin
                stall_q <= 1'b1;
            end

            if (slot_pick && done_cnt != 16'hFFFF) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule
